// File: rtl/op_stack_pkg.sv
// Shared definitions for the operand stack: opcode encodings and width helpers.
package op_stack_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_SWAP  = 3'd3,
        OP_DUP   = 3'd4,
        OP_OVER  = 3'd5,
        OP_ROT   = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

endpackage

// File: rtl/op_stack_regfile.sv
// Storage array for op_stack: async reads at ptr-1/-2(/-3), three write ports.
// The third read port only exists when OP_STACK_ROT_EN is defined.
module op_stack_regfile #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clock,
    input  logic [$clog2(DEPTH):0]     ptr,
    output logic [WIDTH-1:0]           rd0,
    output logic [WIDTH-1:0]           rd1,
`ifdef OP_STACK_ROT_EN
    output logic [WIDTH-1:0]           rd2,
`endif
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   wa0,
    input  logic [WIDTH-1:0]           wd0,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   wa1,
    input  logic [WIDTH-1:0]           wd1,
    input  logic                       we2,
    input  logic [$clog2(DEPTH)-1:0]   wa2,
    input  logic [WIDTH-1:0]           wd2
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;

    // Read addresses wrap modulo DEPTH; the owner masks positions beyond count.
    always_comb begin
        ra0 = AW'(ptr - CW'(1));
        ra1 = AW'(ptr - CW'(2));
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

`ifdef OP_STACK_ROT_EN
    logic [AW-1:0] ra2;

    // Third element is only needed by ROT.
    always_comb begin
        ra2 = AW'(ptr - CW'(3));
    end

    assign rd2 = mem[ra2];
`endif

    // Write ports never target the same address in one cycle; port order is arbitrary.
    always_ff @(posedge clock) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
        if (we2) mem[wa2] <= wd2;
    end

endmodule

// File: rtl/op_stack.sv
// Operand stack with PUSH/POP/SWAP/DUP/OVER/ROT/CLEAR, post-op top overwrite
// and sticky overflow/underflow flags. ROT is compiled in by OP_STACK_ROT_EN;
// without it op 6 behaves as NOP.
module op_stack
    import op_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             op,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       top,
    output logic [WIDTH-1:0]       next,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             underflow_q;
    logic             ovf_set;
    logic             udf_set;

    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
`ifdef OP_STACK_ROT_EN
    logic [WIDTH-1:0] rd2;
`endif

    logic             we0;
    logic             we1;
    logic             we2;
    logic [AW-1:0]    wa0;
    logic [AW-1:0]    wa1;
    logic [AW-1:0]    wa2;
    logic [WIDTH-1:0] wd0;
    logic [WIDTH-1:0] wd1;
    logic [WIDTH-1:0] wd2;

    logic [AW-1:0]    idx_push;
    logic [AW-1:0]    idx_e0;
    logic [AW-1:0]    idx_e1;
    logic [AW-1:0]    idx_e2;
    logic             is_empty;
    logic             is_full;
    logic             ge2;
    logic             ge3;
    op_t              op_eff;

    op_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clock (clock),
        .ptr   (count_q),
        .rd0   (rd0),
        .rd1   (rd1),
`ifdef OP_STACK_ROT_EN
        .rd2   (rd2),
`endif
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .we2   (we2),
        .wa2   (wa2),
        .wd2   (wd2)
    );

    // Element positions relative to the current count, plus occupancy tests.
    always_comb begin
        idx_push = AW'(count_q);
        idx_e0   = AW'(count_q - CW'(1));
        idx_e1   = AW'(count_q - CW'(2));
        idx_e2   = AW'(count_q - CW'(3));
        is_empty = (count_q == CW'(0));
        is_full  = (count_q == CW'(DEPTH));
        ge2      = (count_q >= CW'(2));
        ge3      = (count_q >= CW'(3));
    end

    // Decode: port 0 always writes the post-op top so wr_en folds into its data.
    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        we0     = 1'b0;
        we1     = 1'b0;
        we2     = 1'b0;
        wa0     = idx_e0;
        wa1     = idx_e1;
        wa2     = idx_e2;
        wd0     = wr_data;
        wd1     = '0;
        wd2     = '0;

        op_eff = op_t'(op);
`ifndef OP_STACK_ROT_EN
        if (op_eff == OP_ROT) op_eff = OP_NOP;
`endif

        case (op_eff)
            OP_NOP: begin
                if (wr_en) begin
                    if (is_empty) begin
                        udf_set = 1'b1;
                    end else begin
                        we0 = 1'b1;
                        wa0 = idx_e0;
                    end
                end
            end
            OP_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    wa0     = idx_push;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    udf_set = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                    we0     = wr_en && ge2;
                    wa0     = idx_e1;
                end
            end
            OP_SWAP: begin
                if (!ge2) begin
                    udf_set = 1'b1;
                end else begin
                    we0 = 1'b1;
                    wa0 = idx_e0;
                    wd0 = wr_en ? wr_data : rd1;
                    we1 = 1'b1;
                    wa1 = idx_e1;
                    wd1 = rd0;
                end
            end
            OP_DUP: begin
                if (is_empty) begin
                    udf_set = 1'b1;
                end else if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    wa0     = idx_push;
                    wd0     = wr_en ? wr_data : rd0;
                    count_d = count_q + CW'(1);
                end
            end
            OP_OVER: begin
                if (!ge2) begin
                    udf_set = 1'b1;
                end else if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    wa0     = idx_push;
                    wd0     = wr_en ? wr_data : rd1;
                    count_d = count_q + CW'(1);
                end
            end
`ifdef OP_STACK_ROT_EN
            OP_ROT: begin
                if (!ge3) begin
                    udf_set = 1'b1;
                end else begin
                    we0 = 1'b1;
                    wa0 = idx_e0;
                    wd0 = wr_en ? wr_data : rd2;
                    we1 = 1'b1;
                    wa1 = idx_e1;
                    wd1 = rd0;
                    we2 = 1'b1;
                    wa2 = idx_e2;
                    wd2 = rd1;
                end
            end
`endif
            OP_CLEAR: begin
                count_d = CW'(0);
            end
            default: begin
                count_d = count_q;
            end
        endcase

        if (reset) begin
            we0 = 1'b0;
            we1 = 1'b0;
            we2 = 1'b0;
        end
    end

    // Pointer and sticky error flags; a new error beats a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= CW'(0);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (ovf_set)      overflow_q  <= 1'b1;
            else if (clr_err) overflow_q  <= 1'b0;
            if (udf_set)      underflow_q <= 1'b1;
            else if (clr_err) underflow_q <= 1'b0;
        end
    end

    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign top       = is_empty ? '0 : rd0;
    assign next      = ge2 ? rd1 : '0;

endmodule

// File: tb/tb_op_stack.sv
// Directed bench for op_stack (WIDTH=32, DEPTH=4); ROT expectations follow OP_STACK_ROT_EN.
module tb_op_stack;
    import op_stack_pkg::*;

    logic        clock;
    logic        reset;
    logic [2:0]  op;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        clr_err;
    logic [31:0] top;
    logic [31:0] next;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    op_stack #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .op        (op),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_err   (clr_err),
        .top       (top),
        .next      (next),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input op_t o, input logic we, input logic [31:0] d,
                        input logic ce, input logic rst);
        op      = o;
        wr_en   = we;
        wr_data = d;
        clr_err = ce;
        reset   = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(OP_NOP, 1'b0, 32'd0, 1'b0, 1'b1);
        step(OP_NOP, 1'b0, 32'd0, 1'b0, 1'b1);
        op    = OP_NOP;
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        step(OP_PUSH, 1'b0, d, 1'b0, 1'b0);
    endtask

    initial begin
        op = OP_NOP; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0; reset = 1'b1;

        // Reset state
        do_reset();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_top", top, 32'd0);
        check_eq("rst_next", next, 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_udf", 32'(underflow), 32'd0);

        // Push / swap / pop-with-replace
        push(32'd5);
        push(32'd7);
        check_eq("push_top", top, 32'd7);
        check_eq("push_next", next, 32'd5);
        step(OP_SWAP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("swap_top", top, 32'd5);
        check_eq("swap_next", next, 32'd7);
        check_eq("swap_count", 32'(count), 32'd2);
        step(OP_POP, 1'b1, 32'd12, 1'b0, 1'b0);
        check_eq("popwr_top", top, 32'd12);
        check_eq("popwr_count", 32'(count), 32'd1);
        check_eq("popwr_next", next, 32'd0);

        // Overflow handling
        do_reset();
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_top", top, 32'd4);
        check_eq("fill_next", next, 32'd3);
        push(32'd9);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd4);
        check_eq("ovf_top", top, 32'd4);
        step(OP_NOP, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        step(OP_DUP, 1'b1, 32'd99, 1'b0, 1'b0);
        check_eq("dupfull_ovf", 32'(overflow), 32'd1);
        check_eq("dupfull_top", top, 32'd4);
        check_eq("dupfull_count", 32'(count), 32'd4);
        step(OP_NOP, 1'b0, 32'd0, 1'b1, 1'b0);
        step(OP_OVER, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("overfull_ovf", 32'(overflow), 32'd1);
        check_eq("overfull_next", next, 32'd3);

        // Underflow handling
        do_reset();
        step(OP_POP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("udf_flag", 32'(underflow), 32'd1);
        check_eq("udf_count", 32'(count), 32'd0);
        check_eq("udf_top", top, 32'd0);
        step(OP_POP, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("udf_clr_race", 32'(underflow), 32'd1);
        step(OP_NOP, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("udf_clr", 32'(underflow), 32'd0);
        step(OP_NOP, 1'b1, 32'd5, 1'b0, 1'b0);
        check_eq("nopwr_udf", 32'(underflow), 32'd1);
        check_eq("nopwr_count", 32'(count), 32'd0);
        step(OP_PUSH, 1'b0, 32'd6, 1'b1, 1'b0);
        check_eq("pushclr_udf", 32'(underflow), 32'd0);
        check_eq("pushclr_top", top, 32'd6);
        step(OP_SWAP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("swap1_udf", 32'(underflow), 32'd1);
        check_eq("swap1_top", top, 32'd6);
        step(OP_OVER, 1'b1, 32'd3, 1'b1, 1'b0);
        check_eq("over1_udf", 32'(underflow), 32'd1);
        check_eq("over1_count", 32'(count), 32'd1);
        check_eq("over1_top", top, 32'd6);

        // ROT
        do_reset();
        push(32'd1); push(32'd2); push(32'd3);
        step(OP_ROT, 1'b0, 32'd0, 1'b0, 1'b0);
`ifdef OP_STACK_ROT_EN
        check_eq("rot_top", top, 32'd1);
        check_eq("rot_next", next, 32'd3);
        check_eq("rot_count", 32'(count), 32'd3);
        check_eq("rot_udf", 32'(underflow), 32'd0);
        step(OP_POP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("rotpop_top", top, 32'd3);
        check_eq("rotpop_next", next, 32'd2);
        step(OP_ROT, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("rot2_udf", 32'(underflow), 32'd1);
        check_eq("rot2_top", top, 32'd3);
`else
        check_eq("rot_top", top, 32'd3);
        check_eq("rot_next", next, 32'd2);
        check_eq("rot_count", 32'(count), 32'd3);
        check_eq("rot_udf", 32'(underflow), 32'd0);
        step(OP_POP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("rotpop_top", top, 32'd2);
        check_eq("rotpop_next", next, 32'd1);
        step(OP_ROT, 1'b1, 32'd40, 1'b0, 1'b0);
        check_eq("rot2_udf", 32'(underflow), 32'd0);
        check_eq("rot2_top", top, 32'd40);
`endif

        // DUP / OVER / CLEAR and wr_en variants
        do_reset();
        push(32'd6);
        step(OP_DUP, 1'b0, 32'd0, 1'b0, 1'b0);
        step(OP_OVER, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("dov_count", 32'(count), 32'd3);
        check_eq("dov_top", top, 32'd6);
        check_eq("dov_next", next, 32'd6);
        step(OP_CLEAR, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_empty", 32'(empty), 32'd1);
        check_eq("clr_top", top, 32'd0);
        push(32'd5);
        check_eq("stale_next", next, 32'd0);
        push(32'd2);
        step(OP_OVER, 1'b1, 32'd11, 1'b0, 1'b0);
        check_eq("overwr_top", top, 32'd11);
        check_eq("overwr_next", next, 32'd2);
        step(OP_DUP, 1'b1, 32'd13, 1'b0, 1'b0);
        check_eq("dupwr_top", top, 32'd13);
        check_eq("dupwr_next", next, 32'd11);
        check_eq("dupwr_full", 32'(full), 32'd1);
        step(OP_SWAP, 1'b1, 32'd21, 1'b0, 1'b0);
        check_eq("swapwr_top", top, 32'd21);
        check_eq("swapwr_next", next, 32'd13);
        step(OP_CLEAR, 1'b1, 32'd7, 1'b0, 1'b0);
        check_eq("clrwr_count", 32'(count), 32'd0);
        check_eq("clrwr_top", top, 32'd0);

        // Reset coincident with PUSH after errors are set
        push(32'd1);
        step(OP_POP, 1'b0, 32'd0, 1'b0, 1'b0);
        step(OP_POP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("pre_rst_udf", 32'(underflow), 32'd1);
        step(OP_PUSH, 1'b1, 32'd8, 1'b0, 1'b1);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_top", top, 32'd0);
        check_eq("midrst_ovf", 32'(overflow), 32'd0);
        check_eq("midrst_udf", 32'(underflow), 32'd0);
        step(OP_NOP, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("postrst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/op_stack.md
OP_STACK -- requirements
Module: op_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, maximum element count (power of two, >=4).
REQ-003 SHALL have port clock  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port op  input  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 SWAP, 4 DUP, 5 OVER, 6 ROT, 7 CLEAR.
REQ-006 SHALL have port wr_en  input  1  overwrite the post-op top with wr_data.
REQ-007 SHALL have port wr_data  input  WIDTH  value for PUSH or for the wr_en overwrite.
REQ-008 SHALL have port clr_err  input  1  clear the sticky error flags.
REQ-009 SHALL have ports top/next  output  WIDTH  element 0 / element 1 from top; 0 when absent.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current element count, 0..DEPTH.
REQ-011 SHALL have ports empty/full  output  1  count==0 / count==DEPTH.
REQ-012 SHALL have ports overflow/underflow  output  1  sticky error flags.

Function
REQ-013 SHALL execute one op per cycle; top/next/count/empty/full SHALL reflect it the cycle after the edge (latency 1), driven from registers only.
REQ-014 PUSH SHALL append wr_data (count+1); POP SHALL discard the top (count-1).
REQ-015 SWAP SHALL exchange elements 0 and 1; DUP SHALL push a copy of the top; OVER SHALL push a copy of element 1.
REQ-016 ROT SHALL rotate the top three (a,b,c with a on top -> c,a,b with c on top); count unchanged.
REQ-017 CLEAR SHALL set count to 0; error flags unchanged.
REQ-018 wr_en SHALL write wr_data into the top as it stands after op in the same edge (POP+wr_en = replace the two top operands with a result); wr_en with PUSH SHALL be redundant; wr_en with CLEAR SHALL be ignored.
REQ-019 PUSH, DUP or OVER at full SHALL set overflow and leave all state unchanged, wr_en included.
REQ-020 POP or DUP with count<1, SWAP or OVER with count<2, ROT with count<3, or NOP+wr_en with count 0, SHALL set underflow and leave all state unchanged.
REQ-021 Error flags SHALL stay set until reset or clr_err; when clr_err coincides with a new error, the new error SHALL win.
REQ-022 Elements at positions >= count SHALL never be observable on top/next.

Reset
REQ-023 reset SHALL take priority over every other input in the same cycle.
REQ-024 After reset: count=0, empty=1, full=0, top=0, next=0, overflow=0, underflow=0; array contents need not be cleared.
REQ-025 reset asserted mid-sequence SHALL discard the coincident op and wr_en.

Configuration
REQ-026 Macro OP_STACK_ROT_EN SHALL compile ROT in; with it defined, ROT SHALL behave per REQ-016/REQ-020.
REQ-027 Without OP_STACK_ROT_EN, op 6 SHALL act as NOP (wr_en still honoured), raise no error, and no third read port SHALL be built.

Structure
REQ-028 Package op_stack_pkg SHALL hold the op enum typedef (op_t) and its encodings; WIDTH/DEPTH remain module parameters.
REQ-029 Sub-module op_stack_regfile SHALL hold the DEPTH x WIDTH array with asynchronous read ports at pointer-1/-2/-3 and up to three writes per cycle; op_stack SHALL own the pointer, decode and error logic.

Verification (WIDTH=32, DEPTH=4)
REQ-030 reset; PUSH 5; PUSH 7; SWAP -> top=5, next=7, count=2; POP+wr_en 12 -> top=12, count=1.
REQ-031 PUSH 1,2,3,4 -> full=1; PUSH 9 -> overflow=1, count=4, top=4; clr_err -> overflow=0.
REQ-032 from empty: POP -> underflow=1, count=0, top=0; coincident clr_err and POP -> underflow stays 1.
REQ-033 PUSH 1,2,3; ROT -> top=1, next=3, count=3 (ROT_EN); same stimulus without ROT_EN -> top=3, next=2, no error.
REQ-034 PUSH 6; DUP; OVER -> count=3, top=6, next=6; CLEAR -> count=0, empty=1, top=0.
REQ-035 PUSH 8 with reset high in the same cycle -> count=0, top=0, both error flags 0.
